// File: rtl/sonic_tx_st_packer.sv
// sonic_tx_st_packer: packs a 64-bit TX TLP qword stream into 128-bit Avalon-ST beats
//
// Purpose
//   Sits between the streaming-port TX output and the PCIe hard IP tx_st_* inputs.
//   Qwords pair up into 128-bit beats and are buffered in a small FIFO.
//   Beats are released under the hard IP ready-latency rule.
//   SOP/EOP framing violations on the input stream are repaired and counted.
//
// Ports
//   clk_in         in   1    application clock, rising edge
//   rstn           in   1    synchronous reset, active low
//   in_data        in   64   qword payload
//   in_sop         in   1    first qword of TLP
//   in_eop         in   1    last qword of TLP
//   in_err         in   1    poison/abort for this TLP
//   in_valid       in   1    qword present
//   in_ready       out  1    qword accepted this cycle (registered)
//   tx_st_data     out  128  lane0=[63:0], lane1=[127:64]
//   tx_st_sop      out  1    TLP start (lane0)
//   tx_st_eop      out  1    TLP end
//   tx_st_empty    out  1    lane1 unused (EOP beat only)
//   tx_st_err      out  1    TLP error
//   tx_st_valid    out  1    beat valid
//   tx_st_ready    in   1    hard IP ready, READY_LATENCY semantics
//   proto_err_cnt  out  16   saturating framing-violation count
//   fifo_level     out  AW+1 FIFO occupancy
module sonic_tx_st_packer #(
    parameter int READY_LATENCY = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk_in,
    input  logic                          rstn,
    input  logic [63:0]                   in_data,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic                          in_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [127:0]                  tx_st_data,
    output logic                          tx_st_sop,
    output logic                          tx_st_eop,
    output logic                          tx_st_empty,
    output logic                          tx_st_err,
    output logic                          tx_st_valid,
    input  logic                          tx_st_ready,
    output logic [15:0]                   proto_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = (READY_LATENCY > 1) ? READY_LATENCY - 1 : 1;
    localparam logic [AW:0] LVL_LIMIT = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0] LVL_FULL  = (AW+1)'(FIFO_DEPTH);

    // assembly state
    logic [63:0]  lane0_q, lane0_d;
    logic         sop0_q, sop0_d;
    logic         half_q, half_d;
    logic         err_acc_q, err_acc_d;
    logic         in_pkt_q, in_pkt_d;
    logic         pend_q, pend_d;
    logic         in_ready_q, in_ready_d;
    logic [15:0]  cnt_q, cnt_d;

    // FIFO
    logic [127:0]          fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_sop_q, fifo_eop_q, fifo_empty_q;
    logic [FIFO_DEPTH-1:0] ent_err_q, ent_err_d;
    logic [FIFO_DEPTH-1:0] ent_open_q, ent_open_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;

    // ready history and output registers
    logic [HW-1:0] rdy_hist_q, rdy_hist_d;
    logic [HW:0]   rdy_vec;
    logic [127:0]  data_q, data_d;
    logic          tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
    logic          tx_empty_q, tx_empty_d, tx_err_q, tx_err_d;
    logic          valid_q, valid_d;

    // write port
    logic         wr_en, wr_sop, wr_eop, wr_empty, wr_err;
    logic [127:0] wr_data;

    logic xfer, viol, stray, take, acc, patch, pop;

    assign xfer  = in_valid & in_ready_q;
    assign viol  = xfer & in_sop & in_pkt_q;
    assign stray = xfer & ~in_sop & ~in_pkt_q;
    assign take  = xfer & ~stray;
    assign acc   = (in_sop ? 1'b0 : err_acc_q) | in_err;
    // late in_err poisons beats of the same TLP still waiting in the FIFO
    assign patch = xfer & in_err & in_pkt_q & ~in_sop;

    // rdy_vec[k] = tx_st_ready k cycles ago (k=0 is the current cycle)
    assign rdy_vec = {rdy_hist_q, tx_st_ready};
    assign pop     = rdy_vec[READY_LATENCY-1] && (level_q != '0);

    always_comb begin
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        wr_empty  = 1'b0;
        wr_err    = 1'b0;
        lane0_d   = lane0_q;
        sop0_d    = sop0_q;
        half_d    = half_q;
        err_acc_d = err_acc_q;
        in_pkt_d  = in_pkt_q;
        pend_d    = 1'b0;
        if (pend_q) begin
            // single-qword TLP parked behind a flush beat
            wr_en    = 1'b1;
            wr_data  = {64'h0, lane0_q};
            wr_sop   = sop0_q;
            wr_eop   = 1'b1;
            wr_empty = 1'b1;
            wr_err   = err_acc_q;
            half_d   = 1'b0;
        end else if (viol && half_q) begin
            // close the broken TLP, the new sop qword takes lane0
            wr_en     = 1'b1;
            wr_data   = {64'h0, lane0_q};
            wr_sop    = sop0_q;
            wr_eop    = 1'b1;
            wr_empty  = 1'b1;
            wr_err    = 1'b1;
            lane0_d   = in_data;
            sop0_d    = 1'b1;
            err_acc_d = in_err;
            half_d    = 1'b1;
            pend_d    = in_eop;
            in_pkt_d  = ~in_eop;
        end else if (take) begin
            err_acc_d = acc;
            in_pkt_d  = ~in_eop;
            if (half_q) begin
                wr_en    = 1'b1;
                wr_data  = {in_data, lane0_q};
                wr_sop   = sop0_q;
                wr_eop   = in_eop;
                wr_err   = acc;
                half_d   = 1'b0;
            end else if (in_eop) begin
                wr_en    = 1'b1;
                wr_data  = {64'h0, in_data};
                wr_sop   = in_sop;
                wr_eop   = 1'b1;
                wr_empty = 1'b1;
                wr_err   = acc;
                half_d   = 1'b0;
            end else begin
                lane0_d = in_data;
                sop0_d  = in_sop;
                half_d  = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d      = ((viol | stray) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        ent_err_d  = ent_err_q | ({FIFO_DEPTH{patch}} & ent_open_q);
        ent_open_d = (wr_en && wr_eop) ? '0 : ent_open_q;
        if (wr_en) begin
            ent_err_d[wr_ptr_q]  = wr_err;
            ent_open_d[wr_ptr_q] = ~wr_eop;
        end
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        in_ready_d = (level_d <= LVL_LIMIT) && !pend_d;
        rdy_hist_d = rdy_vec[HW-1:0];
        valid_d    = pop;
        data_d     = pop ? fifo_data_q[rd_ptr_q] : data_q;
        tx_sop_d   = pop ? fifo_sop_q[rd_ptr_q] : tx_sop_q;
        tx_eop_d   = pop ? fifo_eop_q[rd_ptr_q] : tx_eop_q;
        tx_empty_d = pop ? fifo_empty_q[rd_ptr_q] : tx_empty_q;
        tx_err_d   = pop ? (ent_err_q[rd_ptr_q] | (patch & ent_open_q[rd_ptr_q])) : tx_err_q;
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            fifo_data_q[wr_ptr_q]  <= wr_data;
            fifo_sop_q[wr_ptr_q]   <= wr_sop;
            fifo_eop_q[wr_ptr_q]   <= wr_eop;
            fifo_empty_q[wr_ptr_q] <= wr_empty;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            lane0_q    <= '0;
            sop0_q     <= 1'b0;
            half_q     <= 1'b0;
            err_acc_q  <= 1'b0;
            in_pkt_q   <= 1'b0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            ent_err_q  <= '0;
            ent_open_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rdy_hist_q <= '0;
            data_q     <= '0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_empty_q <= 1'b0;
            tx_err_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            lane0_q    <= lane0_d;
            sop0_q     <= sop0_d;
            half_q     <= half_d;
            err_acc_q  <= err_acc_d;
            in_pkt_q   <= in_pkt_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            ent_err_q  <= ent_err_d;
            ent_open_q <= ent_open_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rdy_hist_q <= rdy_hist_d;
            data_q     <= data_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            tx_empty_q <= tx_empty_d;
            tx_err_q   <= tx_err_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rstn) assert (!(wr_en && level_q == LVL_FULL));
    end

    assign in_ready      = in_ready_q;
    assign tx_st_data    = data_q;
    assign tx_st_sop     = tx_sop_q;
    assign tx_st_eop     = tx_eop_q;
    assign tx_st_empty   = tx_empty_q;
    assign tx_st_err     = tx_err_q;
    assign tx_st_valid   = valid_q;
    assign proto_err_cnt = cnt_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_sonic_tx_st_packer.sv
// tb_sonic_tx_st_packer: directed scoreboard bench for sonic_tx_st_packer
module tb_sonic_tx_st_packer;

    localparam int RL = 2;
    localparam int D  = 8;

    logic         clk_in = 1'b0;
    logic         rstn = 1'b0;
    logic [63:0]  in_data = '0;
    logic         in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0, in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] tx_st_data;
    logic         tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err, tx_st_valid;
    logic         tx_st_ready = 1'b0;
    logic [15:0]  proto_err_cnt;
    logic [3:0]   fifo_level;

    sonic_tx_st_packer #(.READY_LATENCY(RL), .FIFO_DEPTH(D)) dut (
        .clk_in(clk_in), .rstn(rstn),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
        .in_valid(in_valid), .in_ready(in_ready),
        .tx_st_data(tx_st_data), .tx_st_sop(tx_st_sop), .tx_st_eop(tx_st_eop),
        .tx_st_empty(tx_st_empty), .tx_st_err(tx_st_err), .tx_st_valid(tx_st_valid),
        .tx_st_ready(tx_st_ready), .proto_err_cnt(proto_err_cnt), .fifo_level(fifo_level)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [127:0] d;
        logic         sop;
        logic         eop;
        logic         empty;
        logic         err;
    } beat_t;

    beat_t exp_q[$];
    int    n_assert = 0;
    int    n_fail = 0;
    logic [3:0] rh = '0;
    logic  done = 1'b0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // output monitor: every valid beat must be backed by ready history and match the scoreboard
    always @(negedge clk_in) begin
        if (tx_st_valid === 1'b1) begin
            chk("valid_vs_ready_history", 160'(rh[RL-1]), 160'd1);
            if (exp_q.size() == 0)
                chk("beat_expected", 160'(exp_q.size()), 160'd1);
            else
                chk("beat", 160'({tx_st_data, tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err}),
                    160'(exp_q.pop_front()));
        end
        rh = {rh[2:0], tx_st_ready};
    end

    function automatic logic [63:0] qw(input int b, input int i);
        return {b[31:0], i[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic er);
        int w = 0;
        in_data = d; in_sop = s; in_eop = e; in_err = er; in_valid = 1'b1;
        @(negedge clk_in);
        while (in_ready !== 1'b1 && w < 500) begin
            @(negedge clk_in);
            w++;
        end
        chk("send_accept", 160'(w < 500), 160'd1);
        @(posedge clk_in);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
    endtask

    task automatic push(input logic [127:0] d, input logic s, input logic e, input logic em, input logic er);
        beat_t b;
        b.d = d; b.sop = s; b.eop = e; b.empty = em; b.err = er;
        exp_q.push_back(b);
    endtask

    task automatic send_tlp(input int n, input int b);
        for (int j = 0; 2*j < n; j++) begin
            if (2*j+1 < n) push({qw(b, 2*j+1), qw(b, 2*j)}, j == 0, 2*j+2 == n, 1'b0, 1'b0);
            else           push({64'h0, qw(b, 2*j)}, j == 0, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < n; i++) send(qw(b, i), i == 0, i == n-1, 1'b0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            tick();
            w++;
        end
        chk("drain", 160'(exp_q.size()), 160'd0);
    endtask

    initial begin
        int lens[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9};
        // reset with input activity
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = '1; tx_st_ready = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            chk("reset_outputs", 160'({tx_st_data, tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err,
                tx_st_valid, in_ready, proto_err_cnt, fifo_level}), 160'd0);
        end
        tick();
        rstn = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clk_in);
        chk("in_ready_release_cycle", 160'(in_ready), 160'd0);
        tick();
        @(negedge clk_in);
        chk("in_ready_after_release", 160'(in_ready), 160'd1);
        tick();

        // 2-qword TLP, minimum latency
        push({64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 1'b1, 1'b1, 1'b0, 1'b0);
        send(64'hAAAA_0000_0000_000A, 1'b1, 1'b0, 1'b0);
        send(64'hBBBB_0000_0000_000B, 1'b0, 1'b1, 1'b0);
        @(negedge clk_in);
        chk("latency_t1_valid", 160'(tx_st_valid), 160'd0);
        tick();
        @(negedge clk_in);
        chk("latency_t2_valid", 160'(tx_st_valid), 160'd1);
        tick();

        // 5-qword TLP, in_err on Q2 poisons all buffered beats
        tx_st_ready = 1'b0;
        repeat (4) tick();
        push({qw(3, 1), qw(3, 0)}, 1'b1, 1'b0, 1'b0, 1'b1);
        push({qw(3, 3), qw(3, 2)}, 1'b0, 1'b0, 1'b0, 1'b1);
        push({64'h0, qw(3, 4)}, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(qw(3, i), i == 0, i == 4, i == 2);
        @(negedge clk_in);
        chk("five_qword_level", 160'(fifo_level), 160'd3);
        tick();
        tx_st_ready = 1'b1;
        drain();

        // 64 qwords with random ready
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 11; k++) send_tlp(lens[k], 16 + k);
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!done && c < 3000) begin
                    tick();
                    tx_st_ready = 1'($urandom_range(0, 1));
                    c++;
                end
            end
        join
        tx_st_ready = 1'b1;
        drain();

        // long backpressure, then exact ready->valid spacing
        tx_st_ready = 1'b0;
        repeat (3) tick();
        fork
            send_tlp(24, 64);
            begin
                repeat (100) tick();
                @(negedge clk_in);
                chk("bp_level", 160'(fifo_level == 4'(D-1) || fifo_level == 4'(D)), 160'd1);
                chk("bp_in_ready", 160'(in_ready), 160'd0);
                tick();
                tx_st_ready = 1'b1;
                @(negedge clk_in);
                tick();
                @(negedge clk_in);
                chk("rdy_valid_r1", 160'(tx_st_valid), 160'd0);
                tick();
                @(negedge clk_in);
                chk("rdy_valid_r2", 160'(tx_st_valid), 160'd1);
                tick();
                tx_st_ready = 1'b0;
                @(negedge clk_in);
                chk("drop_committed_1", 160'(tx_st_valid), 160'd1);
                tick();
                @(negedge clk_in);
                chk("drop_committed_2", 160'(tx_st_valid), 160'd1);
                tick();
                @(negedge clk_in);
                chk("drop_valid_low", 160'(tx_st_valid), 160'd0);
                tick();
                tx_st_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk_in);
        chk("bp_level_empty", 160'(fifo_level), 160'd0);
        tick();

        // framing violations
        push({64'h0, 64'hDEAD_0000_0000_0001}, 1'b1, 1'b1, 1'b1, 1'b1);
        push({64'h0, 64'hDEAD_0000_0000_0002}, 1'b1, 1'b1, 1'b1, 1'b0);
        send(64'hDEAD_0000_0000_0001, 1'b1, 1'b0, 1'b0);
        send(64'hDEAD_0000_0000_0002, 1'b1, 1'b1, 1'b0);
        @(negedge clk_in);
        chk("cnt_sop_mid_tlp", 160'(proto_err_cnt), 160'd1);
        tick();
        send(64'hDEAD_0000_0000_0003, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        chk("cnt_stray", 160'(proto_err_cnt), 160'd2);
        tick();
        drain();

        // reset mid-packet
        send(qw(7, 0), 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        repeat (2) tick();
        @(negedge clk_in);
        chk("midpkt_reset_outputs", 160'({tx_st_data, tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err,
            tx_st_valid, in_ready, proto_err_cnt, fifo_level}), 160'd0);
        tick();
        rstn = 1'b1;
        tick();
        send(qw(7, 1), 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        chk("in_pkt_cleared", 160'(proto_err_cnt), 160'd1);
        tick();
        send_tlp(2, 8);
        drain();

        // counter saturation
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'h5;
        repeat (65533) tick();
        @(negedge clk_in);
        chk("cnt_below_sat", 160'(proto_err_cnt), 160'hFFFE);
        repeat (10) tick();
        in_valid = 1'b0;
        @(negedge clk_in);
        chk("cnt_saturated", 160'(proto_err_cnt), 160'hFFFF);
        chk("sat_level", 160'(fifo_level), 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
